// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (A) and load-return (B) writebacks onto the single register-file write port.
// Latency: a request chosen in cycle N drives rf_* in cycle N+1; queued B writes drain into idle slots.
// Backpressure: A never stalls; B stalls via b_ready when the FIFO is full. Optional: REGFILE_WB_R0_DISCARD_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_valid,
    input  logic [3:0]             a_reg,
    input  logic [DW-1:0]          a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [3:0]             b_reg,
    input  logic [DW-1:0]          b_data,
    output logic                   rf_write_reg,
    output logic [3:0]             rf_dst_reg,
    output logic [DW-1:0]          rf_dst_data,
    output logic [15:0]            pending,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef REGFILE_WB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    // FIFO storage; a cleared live bit marks an entry overtaken by a younger A write
    logic [DEPTH-1:0] entryLive;
    logic [3:0]       entryReg  [DEPTH];
    logic [DW-1:0]    entryData [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;

    logic             fifoEmpty;
    logic             fifoFull;
    logic             aDrop;
    logic             bDrop;
    logic             aStage;
    logic             doPop;
    logic             bypass;
    logic             doPush;
    logic             pushLive;
    logic [DEPTH-1:0] squash;
    logic [DEPTH-1:0] liveNext;
    logic             stageVld;
    logic [3:0]       stageReg;
    logic [DW-1:0]    stageData;
    logic [15:0]      pendingVec;

    assign fifoEmpty = (fifo_count == '0);
    assign fifoFull  = (fifo_count == CW'(DEPTH));
    assign b_ready   = !fifoFull;
    assign aDrop     = R0_DISCARD && (a_reg == 4'd0);
    assign bDrop     = R0_DISCARD && (b_reg == 4'd0);

    // Slot arbitration: A first, then FIFO head, then B bypass when the FIFO is empty
    always_comb begin
        aStage    = a_valid && !aDrop;
        doPop     = !aStage && !fifoEmpty;
        bypass    = !aStage && fifoEmpty && b_valid;
        doPush    = b_valid && b_ready && !bypass && !bDrop;
        pushLive  = !(aStage && (a_reg == b_reg));
        stageVld  = 1'b0;
        stageReg  = rf_dst_reg;
        stageData = rf_dst_data;
        if (aStage) begin
            stageVld  = 1'b1;
            stageReg  = a_reg;
            stageData = a_data;
        end else if (doPop) begin
            stageVld  = entryLive[rdPtr];
            stageReg  = entryReg[rdPtr];
            stageData = entryData[rdPtr];
        end else if (bypass) begin
            stageVld  = !bDrop;
            stageReg  = b_reg;
            stageData = b_data;
        end
    end

    // Live-bit update: squash older same-register entries, retire the popped slot, mark the new entry
    always_comb begin
        squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = aStage && (entryReg[i] == a_reg);
        end
        liveNext = entryLive & ~squash;
        if (doPop) begin
            liveNext[rdPtr] = 1'b0;
        end
        if (doPush) begin
            liveNext[wrPtr] = pushLive;
        end
    end

    // FIFO state: storage, pointers and occupancy; reset discards all queued writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entryLive  <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryReg[i]  <= '0;
                entryData[i] <= '0;
            end
        end else begin
            entryLive <= liveNext;
            if (doPush) begin
                entryReg[wrPtr]  <= b_reg;
                entryData[wrPtr] <= b_data;
                wrPtr            <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (doPush && !doPop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!doPush && doPop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Registered write port; destination/data hold when the slot is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_reg <= 1'b0;
            rf_dst_reg   <= '0;
            rf_dst_data  <= '0;
        end else begin
            rf_write_reg <= stageVld;
            rf_dst_reg   <= stageReg;
            rf_dst_data  <= stageData;
        end
    end

    // Pending mask from registered state only: live FIFO entries plus the staged write
    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryLive[i]) begin
                pendingVec[entryReg[i]] = 1'b1;
            end
        end
        if (rf_write_reg) begin
            pendingVec[rf_dst_reg] = 1'b1;
        end
        if (R0_DISCARD) begin
            pendingVec[0] = 1'b0;
        end
    end

    assign pending = pendingVec;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench with a queue-level reference model and a scoreboard monitor.
// Expected write-port/status values are queued by the driver and consumed on the falling edge.
// B source is a queue of transactions presented under valid/ready.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

`ifdef REGFILE_WB_R0_DISCARD_EN
    localparam bit DISCARD_EN = 1'b1;
`else
    localparam bit DISCARD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid;
    logic [3:0]    a_reg;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [3:0]    b_reg;
    logic [DW-1:0] b_data;
    logic          rf_write_reg;
    logic [3:0]    rf_dst_reg;
    logic [DW-1:0] rf_dst_data;
    logic [15:0]   pending;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .rf_write_reg(rf_write_reg), .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data),
        .pending(pending), .fifo_count(fifo_count)
    );

    typedef struct { bit live; bit [3:0] r; bit [15:0] d; } ent_t;
    typedef struct { bit [3:0] r; bit [15:0] d; } wr_t;
    typedef struct { bit wr; int cnt; bit rdy; bit [15:0] pend; } st_t;

    ent_t     mq[$];     // model FIFO contents
    wr_t      bsrc[$];   // B transactions waiting to be offered
    wr_t      wq[$];     // expected register-file writes, in order
    st_t      stq[$];    // expected per-cycle status
    bit       mStWr;
    bit [3:0] mStReg;
    int       total = 0;
    int       bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit drop(input bit [3:0] r);
        return DISCARD_EN && (r == 4'd0);
    endfunction

    function automatic st_t expStatus();
        st_t s;
        s.pend = '0;
        foreach (mq[i]) if (mq[i].live) s.pend[mq[i].r] = 1'b1;
        if (mStWr) s.pend[mStReg] = 1'b1;
        if (DISCARD_EN) s.pend[0] = 1'b0;
        s.cnt = mq.size();
        s.rdy = (mq.size() < DEPTH);
        s.wr  = mStWr;
        return s;
    endfunction

    // One clock: drive inputs, advance the model, then queue the status the DUT should show
    task automatic step(input bit av, input bit [3:0] ar, input bit [15:0] ad, input bit bEn);
        bit   bv, rdy, aSt, staged, byp;
        wr_t  bh, s;
        ent_t e;
        bv = bEn && (bsrc.size() > 0);
        bh = '{r: 4'd0, d: 16'd0};
        if (bv) bh = bsrc[0];
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = bh.r; b_data = bh.d;

        rdy = (mq.size() < DEPTH);
        aSt = av && !drop(ar);
        staged = 1'b0; byp = 1'b0;
        s = '{r: 4'd0, d: 16'd0};
        if (aSt) begin
            staged = 1'b1; s = '{r: ar, d: ad};
            foreach (mq[i]) if (mq[i].r == ar) begin
                e = mq[i]; e.live = 1'b0; mq[i] = e;
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) begin staged = 1'b1; s = '{r: e.r, d: e.d}; end
        end else if (bv) begin
            byp = 1'b1;
            if (!drop(bh.r)) begin staged = 1'b1; s = bh; end
        end
        if (bv && rdy) begin
            void'(bsrc.pop_front());
            if (!byp && !drop(bh.r))
                mq.push_back('{live: !(aSt && ar == bh.r), r: bh.r, d: bh.d});
        end
        mStWr = staged;
        if (staged) begin mStReg = s.r; wq.push_back(s); end

        @(posedge clk); #1;
        stq.push_back(expStatus());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((mq.size() > 0 || bsrc.size() > 0) && k < 40) begin
            step(1'b0, 4'd0, 16'd0, 1'b1);
            k++;
        end
        chk("drain_bound", 32'(mq.size() + bsrc.size()), 32'd0);
        idle(2);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_wr"},    32'(rf_write_reg), 32'd0);
        chk({tag, "_dst"},   32'(rf_dst_reg),   32'd0);
        chk({tag, "_data"},  32'(rf_dst_data),  32'd0);
        chk({tag, "_pend"},  32'(pending),      32'd0);
        chk({tag, "_count"}, 32'(fifo_count),   32'd0);
        chk({tag, "_ready"}, 32'(b_ready),      32'd1);
    endtask

    // Asynchronous reset pulse mid-cycle; the model forgets everything queued
    task automatic midReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        stq.delete(); wq.delete(); mq.delete(); bsrc.delete();
        mStWr = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stq.push_back(expStatus());
    endtask

    // Scoreboard monitor: compare status every cycle, and each write against the expected order
    always @(negedge clk) begin : monitor
        st_t es;
        wr_t ew;
        if (stq.size() > 0) begin
            es = stq.pop_front();
            chk("write_en",   32'(rf_write_reg), 32'(es.wr));
            chk("fifo_count", 32'(fifo_count),   32'(es.cnt));
            chk("b_ready",    32'(b_ready),      32'(es.rdy));
            chk("pending",    32'(pending),      32'(es.pend));
            if (rf_write_reg) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write actual=reg%0d:%0h required=none", rf_dst_reg, rf_dst_data);
                end else begin
                    ew = wq.pop_front();
                    chk("write_reg",  32'(rf_dst_reg),  32'(ew.r));
                    chk("write_data", 32'(rf_dst_data), 32'(ew.d));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        mStWr = 1'b0; mStReg = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        stq.push_back(expStatus());

        // B bypass into an empty FIFO
        bsrc.push_back('{r: 4'd3, d: 16'h00AA});
        step(1'b0, 4'd0, 16'd0, 1'b1);
        idle(2);

        // A holds the slot for 6 cycles; B fills the FIFO and back-pressures
        for (int i = 1; i <= 6; i++) bsrc.push_back('{r: 4'(i), d: 16'(16'h0100 + i)});
        for (int i = 0; i < 6; i++) step(1'b1, 4'(8 + i), 16'(16'hA000 + i), 1'b1);
        idle(5);
        drain();

        // Queued B write to reg5 overtaken by a younger A write
        bsrc.push_back('{r: 4'd5, d: 16'h1111});
        step(1'b1, 4'd9, 16'h0009, 1'b1);
        step(1'b1, 4'd5, 16'h2222, 1'b0);
        idle(3);

        // Same-cycle A and B to reg7 with FIFO non-empty: B enqueued dead
        bsrc.push_back('{r: 4'd2, d: 16'h0202});
        step(1'b1, 4'd9, 16'h0909, 1'b1);
        bsrc.push_back('{r: 4'd7, d: 16'hBEEF});
        step(1'b1, 4'd7, 16'h0007, 1'b1);
        drain();

        // Register 0 requests (discarded only when the optional feature is built in)
        bsrc.push_back('{r: 4'd0, d: 16'h5A5A});
        step(1'b1, 4'd0, 16'hFFFF, 1'b1);
        idle(3);

        // Reset mid-drain with three queued entries
        for (int i = 0; i < 3; i++) bsrc.push_back('{r: 4'(10 + i), d: 16'(16'hC000 + i)});
        for (int i = 0; i < 3; i++) step(1'b1, 4'd1, 16'(16'h0D00 + i), 1'b1);
        midReset();
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (bsrc.size() < 3 && ($urandom % 2) == 0)
                bsrc.push_back('{r: 4'($urandom % 16), d: 16'($urandom)});
            step(($urandom % 3) == 0, 4'($urandom % 16), 16'($urandom), ($urandom % 4) != 0);
        end
        drain();

        @(negedge clk); #1;
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
